// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - kiosk front-end / dispenser signal bundle for atm_session_ctrl
interface atm_session_ctrl_if #(
    parameter int AMT_W = 8
);
    logic             card_inserted;
    logic             pin_valid;
    logic             pin_correct;
    logic             amt_valid;
    logic [AMT_W-1:0] amount;
    logic [AMT_W-1:0] balance;
    logic             disp_done;
    logic             disp_req;
    logic [AMT_W-1:0] disp_amount;
    logic             debit;
    logic             txn_error;
    logic             card_eject;
    logic             card_retain;
    logic             busy;

    modport master (
        output card_inserted, pin_valid, pin_correct, amt_valid, amount, balance, disp_done,
        input  disp_req, disp_amount, debit, txn_error, card_eject, card_retain, busy
    );

    modport slave (
        input  card_inserted, pin_valid, pin_correct, amt_valid, amount, balance, disp_done,
        output disp_req, disp_amount, debit, txn_error, card_eject, card_retain, busy
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM kiosk session sequencer: PIN retries, timeout, amount check, dispense handshake
module atm_session_ctrl #(
    parameter int PIN_TRIES   = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int AMT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    atm_session_ctrl_if.slave   bus
);
    localparam int                 TIMER_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]         TRIES_MAX = 3'(PIN_TRIES);
    localparam logic [AMT_W-1:0]   ZERO_AMT  = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PIN,
        ST_WAIT_AMT,
        ST_DISPENSE,
        ST_EJECT,
        ST_RETAIN
    } state_t;

    state_t             state;
    logic [2:0]         tries;
    logic [TIMER_W-1:0] timer;
    logic               disp_req_q;
    logic [AMT_W-1:0]   disp_amount_q;
    logic               debit_q;
    logic               txn_error_q;
    logic               card_eject_q;
    logic               card_retain_q;
    logic               busy_q;
    logic               timeout;
    logic               amt_bad;

    assign timeout = (timer == TIMER_MAX);
    assign amt_bad = (bus.amount == ZERO_AMT) || (bus.amount > bus.balance);

    // Level outputs are set on the transition into their state so they are valid one cycle after entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            tries         <= '0;
            timer         <= '0;
            disp_req_q    <= 1'b0;
            disp_amount_q <= '0;
            debit_q       <= 1'b0;
            txn_error_q   <= 1'b0;
            card_eject_q  <= 1'b0;
            card_retain_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            debit_q     <= 1'b0;
            txn_error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.card_inserted) begin
                        state  <= ST_WAIT_PIN;
                        tries  <= '0;
                        timer  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_WAIT_PIN: begin
                    if (!bus.card_inserted) begin
                        state  <= ST_IDLE;
                        timer  <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.pin_valid) begin
                        timer <= '0;
                        if (bus.pin_correct) begin
                            state <= ST_WAIT_AMT;
                        end else begin
                            tries <= tries + 3'd1;
                            if (tries + 3'd1 == TRIES_MAX) begin
                                state         <= ST_RETAIN;
                                card_retain_q <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        state        <= ST_EJECT;
                        timer        <= '0;
                        card_eject_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_AMT: begin
                    if (!bus.card_inserted) begin
                        state  <= ST_IDLE;
                        timer  <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.amt_valid) begin
                        timer <= '0;
                        if (amt_bad) begin
                            state        <= ST_EJECT;
                            txn_error_q  <= 1'b1;
                            card_eject_q <= 1'b1;
                        end else begin
                            state         <= ST_DISPENSE;
                            disp_amount_q <= bus.amount;
                            disp_req_q    <= 1'b1;
                        end
                    end else if (timeout) begin
                        state        <= ST_EJECT;
                        timer        <= '0;
                        card_eject_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    // Card removal is deliberately ignored once cash is committed.
                    if (bus.disp_done) begin
                        state        <= ST_EJECT;
                        disp_req_q   <= 1'b0;
                        debit_q      <= 1'b1;
                        card_eject_q <= 1'b1;
                    end
                end
                ST_EJECT: begin
                    if (!bus.card_inserted) begin
                        state        <= ST_IDLE;
                        card_eject_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                ST_RETAIN: begin
                    if (!bus.card_inserted) begin
                        state         <= ST_IDLE;
                        card_retain_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    timer         <= '0;
                    disp_req_q    <= 1'b0;
                    card_eject_q  <= 1'b0;
                    card_retain_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_amount = disp_amount_q;
    assign bus.debit       = debit_q;
    assign bus.txn_error   = txn_error_q;
    assign bus.card_eject  = card_eject_q;
    assign bus.card_retain = card_retain_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed and randomized checks of atm_session_ctrl against a phase-level model
module tb_atm_session_ctrl;
    localparam int PIN_TRIES   = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int AMT_W       = 8;

    logic clk = 1'b0;
    logic reset;

    atm_session_ctrl_if #(.AMT_W(AMT_W)) bus ();

    atm_session_ctrl #(
        .PIN_TRIES  (PIN_TRIES),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .AMT_W      (AMT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Session phase as a name plus how long we have dwelt in it.
    string phase = "idle";
    int    wrong_pins;
    int    dwell;
    int    m_amt;
    int    e_debit;
    int    e_err;

    int req_cycles;
    int debits;
    int txn_errs;

    task automatic enter(input string p);
        phase = p;
        dwell = 0;
    endtask

    task automatic model_update();
        e_debit = 0;
        e_err   = 0;
        if (reset) begin
            enter("idle");
            wrong_pins = 0;
            m_amt      = 0;
            return;
        end
        dwell++;
        if (phase == "idle") begin
            if (bus.card_inserted) begin
                enter("pin");
                wrong_pins = 0;
            end
        end else if (phase == "pin") begin
            if (!bus.card_inserted) enter("idle");
            else if (bus.pin_valid && bus.pin_correct) enter("amt");
            else if (bus.pin_valid) begin
                wrong_pins++;
                if (wrong_pins == PIN_TRIES) enter("retain");
                else enter("pin");
            end else if (dwell == TIMEOUT_CYC) enter("eject");
        end else if (phase == "amt") begin
            if (!bus.card_inserted) enter("idle");
            else if (bus.amt_valid) begin
                if (int'(bus.amount) == 0 || int'(bus.amount) > int'(bus.balance)) begin
                    e_err = 1;
                    enter("eject");
                end else begin
                    m_amt = int'(bus.amount);
                    enter("dispense");
                end
            end else if (dwell == TIMEOUT_CYC) enter("eject");
        end else if (phase == "dispense") begin
            if (bus.disp_done) begin
                e_debit = 1;
                enter("eject");
            end
        end else begin
            if (!bus.card_inserted) enter("idle");
        end
    endtask

    task automatic compare_all();
        check("busy",        bus.busy,        32'(phase != "idle"));
        check("disp_req",    bus.disp_req,    32'(phase == "dispense"));
        check("disp_amount", bus.disp_amount, m_amt);
        check("debit",       bus.debit,       e_debit);
        check("txn_error",   bus.txn_error,   e_err);
        check("card_eject",  bus.card_eject,  32'(phase == "eject"));
        check("card_retain", bus.card_retain, 32'(phase == "retain"));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        if (bus.disp_req)  req_cycles++;
        if (bus.debit)     debits++;
        if (bus.txn_error) txn_errs++;
        bus.pin_valid = 1'b0;
        bus.amt_valid = 1'b0;
        bus.disp_done = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic give_pin(input logic ok);
        bus.pin_valid   = 1'b1;
        bus.pin_correct = ok;
        step();
    endtask

    task automatic give_amount(input int a, input int b);
        bus.amt_valid = 1'b1;
        bus.amount    = AMT_W'(a);
        bus.balance   = AMT_W'(b);
        step();
    endtask

    task automatic insert_card();
        bus.card_inserted = 1'b1;
        step();
    endtask

    task automatic remove_card();
        bus.card_inserted = 1'b0;
        step();
    endtask

    initial begin
        reset             = 1'b1;
        bus.card_inserted = 1'b0;
        bus.pin_valid     = 1'b0;
        bus.pin_correct   = 1'b0;
        bus.amt_valid     = 1'b0;
        bus.amount        = '0;
        bus.balance       = '0;
        bus.disp_done     = 1'b0;
        step();
        check("reset_busy", bus.busy, 0);
        check("reset_amt",  bus.disp_amount, 0);
        step();

        // Nominal withdrawal
        insert_card();
        check("insert_busy", bus.busy, 1);
        give_pin(1'b1);
        req_cycles = 0; debits = 0;
        give_amount(40, 100);
        check("nom_req", bus.disp_req, 1);
        check("nom_amt", bus.disp_amount, 40);
        repeat (3) step();
        bus.disp_done = 1'b1;
        step();
        check("nom_req_cycles", req_cycles, 4);
        check("nom_debits", debits, 1);
        check("nom_eject", bus.card_eject, 1);
        repeat (3) step();
        check("nom_eject_hold", bus.card_eject, 1);
        remove_card();
        check("nom_idle", bus.busy, 0);

        // Retain on wrong PINs, then tries restart on a new card
        insert_card();
        for (int i = 0; i < PIN_TRIES; i++) begin
            give_pin(1'b0);
            if (i < PIN_TRIES - 1) step();
        end
        check("ret_retain", bus.card_retain, 1);
        check("ret_no_eject", bus.card_eject, 0);
        remove_card();
        insert_card();
        give_pin(1'b0);
        give_pin(1'b0);
        check("ret2_not_yet", bus.card_retain, 0);
        give_pin(1'b0);
        check("ret2_retain", bus.card_retain, 1);
        remove_card();

        // Bad amounts, then amount equal to balance
        req_cycles = 0; txn_errs = 0;
        insert_card();
        give_pin(1'b1);
        give_amount(101, 100);
        check("bad_hi_err", bus.txn_error, 1);
        check("bad_hi_eject", bus.card_eject, 1);
        step();
        remove_card();
        insert_card();
        give_pin(1'b1);
        give_amount(0, 100);
        check("bad_zero_eject", bus.card_eject, 1);
        step();
        remove_card();
        check("bad_err_pulses", txn_errs, 2);
        check("bad_no_req", req_cycles, 0);
        insert_card();
        give_pin(1'b1);
        give_amount(100, 100);
        check("eq_req", bus.disp_req, 1);
        check("eq_amt", bus.disp_amount, 100);
        bus.disp_done = 1'b1;
        step();
        remove_card();

        // Timeout in WAIT_PIN, and a strobe on the last cycle restarting the timer
        insert_card();
        repeat (TIMEOUT_CYC - 1) step();
        check("to_early", bus.card_eject, 0);
        step();
        check("to_eject", bus.card_eject, 1);
        remove_card();
        insert_card();
        repeat (TIMEOUT_CYC - 1) step();
        give_pin(1'b1);
        check("to_strobe_wins", bus.card_eject, 0);
        repeat (TIMEOUT_CYC - 1) step();
        check("to_amt_early", bus.card_eject, 0);
        step();
        check("to_amt_eject", bus.card_eject, 1);
        remove_card();

        // Card removal in WAIT_AMT and in DISPENSE
        insert_card();
        give_pin(1'b1);
        remove_card();
        check("rm_amt_idle", bus.busy, 0);
        check("rm_amt_no_eject", bus.card_eject, 0);
        insert_card();
        give_pin(1'b1);
        give_amount(30, 60);
        bus.card_inserted = 1'b0;
        repeat (3) step();
        check("rm_disp_req", bus.disp_req, 1);
        bus.disp_done = 1'b1;
        step();
        check("rm_disp_debit", bus.debit, 1);
        check("rm_disp_eject", bus.card_eject, 1);
        step();
        check("rm_disp_idle", bus.busy, 0);

        // Reset during DISPENSE
        insert_card();
        give_pin(1'b1);
        give_amount(20, 50);
        check("rst_req", bus.disp_req, 1);
        debits = 0;
        reset = 1'b1;
        step();
        check("rst_req_low", bus.disp_req, 0);
        check("rst_busy_low", bus.busy, 0);
        check("rst_amt_zero", bus.disp_amount, 0);
        bus.disp_done = 1'b1;
        step();
        check("rst_no_debit", debits, 0);
        remove_card();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [AMT_W-1:0] bal;
            bal = AMT_W'($urandom);
            if ($urandom_range(0, 11) == 0) bus.card_inserted = ~bus.card_inserted;
            bus.pin_valid   = ($urandom_range(0, 5) == 0);
            bus.pin_correct = ($urandom_range(0, 2) != 0);
            bus.amt_valid   = ($urandom_range(0, 4) == 0);
            bus.balance     = bal;
            case ($urandom_range(0, 3))
                0:       bus.amount = '0;
                1:       bus.amount = bal;
                2:       bus.amount = bal + 1'b1;
                default: bus.amount = AMT_W'($urandom);
            endcase
            bus.disp_done = ($urandom_range(0, 3) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
